// File: rtl/coherency_responder_pkg.sv
// -----------------------------------------------------------------------------
// coherency_responder_pkg
// Shared types and helpers for the coherency bus responder.
//   bus_type_e     : encoding of the broadcast transaction type
//   resp_state_e   : responder FSM states
//   lowest_set_idx : index of the lowest asserted bit (owner selection)
//   onehot_of      : one-hot vector for a core index (response strobe)
//   multi_bit      : true when more than one bit of a vector is set
// Helpers operate on MAX_CORES-wide vectors; callers zero-extend/truncate.
// -----------------------------------------------------------------------------
package coherency_responder_pkg;

    localparam int MAX_CORES = 32;
    localparam int IDX_W     = $clog2(MAX_CORES);

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        BUS_RD   = 2'b01,
        BUS_RDX  = 2'b10,
        BUS_UPGR = 2'b11
    } bus_type_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SNOOP    = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        WB_REQ   = 3'd4,
        RESP     = 3'd5
    } resp_state_e;

    // Scan from the top so the last write wins with the lowest index.
    function automatic logic [IDX_W-1:0] lowest_set_idx(input logic [MAX_CORES-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_CORES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [MAX_CORES-1:0] onehot_of(input logic [IDX_W-1:0] id);
        logic [MAX_CORES-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic multi_bit(input logic [MAX_CORES-1:0] v);
        return (v & (v - MAX_CORES'(1))) != '0;
    endfunction

endpackage

// File: rtl/coherency_responder_if.sv
// -----------------------------------------------------------------------------
// coherency_responder_if
// Bundle of the bus-side signals of the coherency responder:
//   broadcast  : bus_valid, bus_type, bus_addr, granted_core_id
//   snoop      : snoop_resp, snoop_data (NUM_CORES lines, core 0 in the LSBs)
//   writeback  : wb_valid, wb_addr, wb_data, wb_ready
//   memory     : mem_req_valid/write/addr/wdata, mem_req_ready,
//                mem_resp_valid, mem_resp_rdata
//   response   : core_resp_valid (one-hot), core_resp_data
// slave  : the responder's view
// master : the system (caches, arbiter, memory) view
// -----------------------------------------------------------------------------
interface coherency_responder_if #(
    parameter int NUM_CORES  = 4,
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64
);
    localparam int ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic                            bus_valid;
    logic [1:0]                      bus_type;
    logic [ADDR_WIDTH-1:0]           bus_addr;
    logic [ID_W-1:0]                 granted_core_id;
    logic [NUM_CORES-1:0]            snoop_resp;
    logic [NUM_CORES*DATA_WIDTH-1:0] snoop_data;
    logic                            wb_valid;
    logic [ADDR_WIDTH-1:0]           wb_addr;
    logic [DATA_WIDTH-1:0]           wb_data;
    logic                            wb_ready;
    logic                            mem_req_valid;
    logic                            mem_req_write;
    logic [ADDR_WIDTH-1:0]           mem_req_addr;
    logic [DATA_WIDTH-1:0]           mem_req_wdata;
    logic                            mem_req_ready;
    logic                            mem_resp_valid;
    logic [DATA_WIDTH-1:0]           mem_resp_rdata;
    logic [NUM_CORES-1:0]            core_resp_valid;
    logic [DATA_WIDTH-1:0]           core_resp_data;

    modport slave (
        input  bus_valid, bus_type, bus_addr, granted_core_id,
        input  snoop_resp, snoop_data,
        input  wb_valid, wb_addr, wb_data,
        output wb_ready,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output core_resp_valid, core_resp_data
    );

    modport master (
        output bus_valid, bus_type, bus_addr, granted_core_id,
        output snoop_resp, snoop_data,
        output wb_valid, wb_addr, wb_data,
        input  wb_ready,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  core_resp_valid, core_resp_data
    );

endinterface

// File: rtl/coherency_responder.sv
// -----------------------------------------------------------------------------
// coherency_responder
// Responder end of the shared coherency bus. Accepts one broadcast at a time,
// samples snoop responses for SNOOP_CYCLES cycles, then answers the requester
// with the owner's line, a line fetched from memory, or zero for BusUpgr.
// When idle it also turns writeback requests into memory writes.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus              : coherency_responder_if.slave (bus/snoop/wb/mem/resp)
//   busy             : high whenever the FSM is not IDLE (gates arbiter grant)
//   err_overrun      : sticky, bus_valid arrived while busy (it was dropped)
//   err_multi_owner  : sticky, more than one snoop_resp bit in a window cycle
// -----------------------------------------------------------------------------
module coherency_responder
    import coherency_responder_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int LINE_BYTES   = 64,
    parameter int DATA_WIDTH   = LINE_BYTES * 8,
    parameter int ADDR_WIDTH   = 64,
    parameter int SNOOP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    coherency_responder_if.slave  bus,
    output logic                  busy,
    output logic                  err_overrun,
    output logic                  err_multi_owner
);

    localparam int ID_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = (SNOOP_CYCLES > 1) ? $clog2(SNOOP_CYCLES) : 1;

    resp_state_e           state_q, state_d;
    bus_type_e             type_q, type_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  hit_q, hit_d;
    logic [DATA_WIDTH-1:0] line_q, line_d;      // snoop/memory line or writeback data
    logic                  err_overrun_q, err_overrun_d;
    logic                  err_multi_q, err_multi_d;

    // Combinational outputs
    logic                  wb_ready_c;
    logic                  mem_valid_c, mem_write_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;
    logic [NUM_CORES-1:0]  resp_valid_c;
    logic [DATA_WIDTH-1:0] resp_data_c;

    // Owner selection: split the flat snoop bus into per-core lines
    logic [DATA_WIDTH-1:0] snoop_lines [NUM_CORES];
    logic [MAX_CORES-1:0]  snoop_ext;
    logic [IDX_W-1:0]      sel_idx;
    logic [DATA_WIDTH-1:0] sel_data;

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_lines
            assign snoop_lines[gi] = bus.snoop_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign snoop_ext = MAX_CORES'(bus.snoop_resp);
    assign sel_idx   = lowest_set_idx(snoop_ext);
    assign sel_data  = snoop_lines[sel_idx[ID_W-1:0]];

    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        addr_d        = addr_q;
        id_d          = id_q;
        cnt_d         = cnt_q;
        hit_d         = hit_q;
        line_d        = line_q;
        err_overrun_d = err_overrun_q;
        err_multi_d   = err_multi_q;
        wb_ready_c    = 1'b0;
        mem_valid_c   = 1'b0;
        mem_write_c   = 1'b0;
        mem_addr_c    = '0;
        mem_wdata_c   = '0;
        resp_valid_c  = '0;
        resp_data_c   = '0;

        // Any broadcast outside IDLE is dropped; only the error is remembered.
        if (bus.bus_valid && (state_q != IDLE)) begin
            err_overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.bus_valid && (bus.bus_type != NONE)) begin
                    type_d  = bus_type_e'(bus.bus_type);
                    addr_d  = bus.bus_addr;
                    id_d    = bus.granted_core_id;
                    cnt_d   = CNT_W'(SNOOP_CYCLES - 1);
                    hit_d   = 1'b0;
                    line_d  = '0;
                    state_d = SNOOP;
                end else if (!bus.bus_valid && bus.wb_valid) begin
                    wb_ready_c = 1'b1;
                    addr_d     = bus.wb_addr;
                    line_d     = bus.wb_data;
                    state_d    = WB_REQ;
                end
            end

            SNOOP: begin
                if (multi_bit(snoop_ext)) begin
                    err_multi_d = 1'b1;
                end
                // First supplier in the window wins; later ones are ignored.
                if (!hit_q && (bus.snoop_resp != '0)) begin
                    hit_d  = 1'b1;
                    line_d = sel_data;
                end
                if (cnt_q == '0) begin
                    state_d = (hit_d || (type_q == BUS_UPGR)) ? RESP : MEM_REQ;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            MEM_REQ: begin
                mem_valid_c = 1'b1;
                mem_addr_c  = addr_q;
                if (bus.mem_req_ready) begin
                    if (bus.mem_resp_valid) begin
                        line_d  = bus.mem_resp_rdata;
                        state_d = RESP;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end
            end

            MEM_WAIT: begin
                if (bus.mem_resp_valid) begin
                    line_d  = bus.mem_resp_rdata;
                    state_d = RESP;
                end
            end

            WB_REQ: begin
                mem_valid_c = 1'b1;
                mem_write_c = 1'b1;
                mem_addr_c  = addr_q;
                mem_wdata_c = line_q;
                if (bus.mem_req_ready) begin
                    state_d = IDLE;
                end
            end

            RESP: begin
                resp_valid_c = NUM_CORES'(onehot_of(IDX_W'(id_q)));
                resp_data_c  = (type_q == BUS_UPGR) ? '0 : line_q;
                state_d      = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            type_q        <= NONE;
            addr_q        <= '0;
            id_q          <= '0;
            cnt_q         <= '0;
            hit_q         <= 1'b0;
            line_q        <= '0;
            err_overrun_q <= 1'b0;
            err_multi_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            addr_q        <= addr_d;
            id_q          <= id_d;
            cnt_q         <= cnt_d;
            hit_q         <= hit_d;
            line_q        <= line_d;
            err_overrun_q <= err_overrun_d;
            err_multi_q   <= err_multi_d;
        end
    end

    assign bus.wb_ready        = wb_ready_c;
    assign bus.mem_req_valid   = mem_valid_c;
    assign bus.mem_req_write   = mem_write_c;
    assign bus.mem_req_addr    = mem_addr_c;
    assign bus.mem_req_wdata   = mem_wdata_c;
    assign bus.core_resp_valid = resp_valid_c;
    assign bus.core_resp_data  = resp_data_c;
    assign busy                = (state_q != IDLE);
    assign err_overrun         = err_overrun_q;
    assign err_multi_owner     = err_multi_q;

endmodule
